// File: rtl/twiddle_addr_sched.sv
// ---------------------------------------------------------------------------
// twiddle_addr_sched
//   Address scheduler for the 384-entry twiddle ROM (rom_384) for one FFT
//   stage pass. On an accepted start it issues N addresses
//   k = (n * 2^stage) mod N for n = 0..N-1, one per unstalled cycle. The
//   modulo is kept incremental, so no multiplier or divider is needed. A
//   last/done marker is delayed to line up with the ROM's output word for
//   n = N-1.
//
// Ports
//   clk       clock, all logic on the rising edge
//   rst       synchronous reset, active-high
//   start     begin a pass (only honoured while idle and not busy)
//   stage     stage index, sampled together with start
//   stall     downstream hold: no address is issued this cycle (RUN only)
//   rom_num   ROM address (to din_num); holds its value while rom_vld=0
//   rom_vld   ROM address valid (to din_vld)
//   last_out  high while the ROM presents the last word of the pass
//   done      1-cycle pulse, identical to last_out
//   busy      pass in progress (RUN or DRAIN)
//   err       1-cycle pulse: start seen with stage > MAX_STAGE
// ---------------------------------------------------------------------------
module twiddle_addr_sched #(
  parameter int N         = 384,
  parameter int A_WIDTH   = 9,
  parameter int S_WIDTH   = 3,
  parameter int MAX_STAGE = 7,
  parameter int ROM_LAT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [S_WIDTH-1:0] stage,
  input  logic               stall,
  output logic [A_WIDTH-1:0] rom_num,
  output logic               rom_vld,
  output logic               last_out,
  output logic               done,
  output logic               busy,
  output logic               err
);

  localparam int CNT_W = $clog2(ROM_LAT + 1);
  localparam logic [A_WIDTH:0]   N_EXT   = (A_WIDTH+1)'(N);
  localparam logic [A_WIDTH-1:0] N_LAST  = A_WIDTH'(N - 1);
  localparam logic [S_WIDTH:0]   MAX_EXT = (S_WIDTH+1)'(MAX_STAGE);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state_reg;
  logic [A_WIDTH-1:0] n_reg;
  logic [A_WIDTH-1:0] k_reg;
  logic [A_WIDTH:0]   stride_reg;
  logic [A_WIDTH-1:0] rom_num_reg;
  logic               rom_vld_reg;
  logic               busy_reg;
  logic               err_reg;
  logic               issue_last_reg;
  logic [CNT_W-1:0]   drain_cnt_reg;
  logic [ROM_LAT-1:0] last_pipe_reg;

  logic [A_WIDTH:0]   k_sum;
  logic [A_WIDTH:0]   k_wrap;
  logic [A_WIDTH-1:0] k_next;
  logic               stage_ok;

  // Next address: one conditional subtract is enough since stride < N and
  // k < N, so k + stride < 2N. The sum carries one extra bit.
  always_comb begin
    k_sum    = {1'b0, k_reg} + stride_reg;
    k_wrap   = k_sum - N_EXT;
    k_next   = (k_sum >= N_EXT) ? k_wrap[A_WIDTH-1:0] : k_sum[A_WIDTH-1:0];
    stage_ok = ({1'b0, stage} <= MAX_EXT);
  end

  // Control FSM with registered outputs. DRAIN covers the cycle holding the
  // final address plus the ROM_LAT cycles that follow it. busy therefore
  // stays high through the done cycle and drops on the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      n_reg          <= '0;
      k_reg          <= '0;
      stride_reg     <= '0;
      rom_num_reg    <= '0;
      rom_vld_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      err_reg        <= 1'b0;
      issue_last_reg <= 1'b0;
      drain_cnt_reg  <= '0;
    end else begin
      rom_vld_reg    <= 1'b0;
      issue_last_reg <= 1'b0;
      err_reg        <= 1'b0;
      case (state_reg)
        IDLE: begin
          busy_reg <= 1'b0;
          if (start) begin
            if (stage_ok) begin
              stride_reg <= (A_WIDTH+1)'(1) << stage;
              n_reg      <= '0;
              k_reg      <= '0;
              busy_reg   <= 1'b1;
              state_reg  <= RUN;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!stall) begin
            rom_vld_reg <= 1'b1;
            rom_num_reg <= k_reg;
            n_reg       <= n_reg + A_WIDTH'(1);
            k_reg       <= k_next;
            if (n_reg == N_LAST) begin
              issue_last_reg <= 1'b1;
              drain_cnt_reg  <= '0;
              n_reg          <= '0;
              state_reg      <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The ROM cannot be held, so stall has no effect here.
          if (drain_cnt_reg == CNT_W'(ROM_LAT)) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Last-word marker delayed by the ROM latency so it coincides with the
  // ROM's dout_vld for address n = N-1. Reset flushes any flag in flight.
  genvar gi;
  generate
    for (gi = 0; gi < ROM_LAT; gi++) begin : g_last_pipe
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst) last_pipe_reg[gi] <= 1'b0;
          else     last_pipe_reg[gi] <= issue_last_reg;
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (rst) last_pipe_reg[gi] <= 1'b0;
          else     last_pipe_reg[gi] <= last_pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  assign rom_num  = rom_num_reg;
  assign rom_vld  = rom_vld_reg;
  assign last_out = last_pipe_reg[ROM_LAT-1];
  assign done     = last_pipe_reg[ROM_LAT-1];
  assign busy     = busy_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_twiddle_addr_sched.sv
module tb_twiddle_addr_sched;

  localparam int N  = 384;
  localparam int AW = 9;
  localparam int SW = 4;
  localparam int MS = 7;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [SW-1:0] stage;
  logic          stall;
  logic [AW-1:0] rom_num;
  logic          rom_vld;
  logic          last_out;
  logic          done;
  logic          busy;
  logic          err;

  twiddle_addr_sched #(
    .N(N), .A_WIDTH(AW), .S_WIDTH(SW), .MAX_STAGE(MS), .ROM_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stage(stage), .stall(stall),
    .rom_num(rom_num), .rom_vld(rom_vld), .last_out(last_out),
    .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int obs[N];
  int pass_len;
  int gap_cycles;

  // Runs one pass: pushes the model's address list, drives start, then
  // checks each issued address against the scoreboard along with the
  // hold, busy and done timing.
  task automatic run_pass(input int stg, input bit no_wait, input int stall_at,
                          input int stall_len, input int poke_at);
    int issued = 0;
    int last_num = -1;
    int first_iter = -1;
    int last_iter = -1;
    int done_iter = -1;
    int done_cnt = 0;
    int stall_left;
    int e;
    bit finished = 0;
    stall_left = stall_len;
    gap_cycles = 0;
    for (int i = 0; i < N; i++) exp_q.push_back((i << stg) % N);
    if (!no_wait) @(negedge clk);
    start = 1'b1;
    stage = SW'(stg);
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || rom_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_stage%0d: busy=%b rom_vld=%b, required busy=1 rom_vld=0", stg, busy, rom_vld);
    end
    for (int it = 1; it < 1000 && !finished; it++) begin
      @(negedge clk);
      start = 1'b0;
      stall = 1'b0;
      if (rom_vld === 1'b1) begin
        if (first_iter < 0) first_iter = it;
        last_iter = it;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_addr_stage%0d: got rom_num=%0d, required no more addresses", stg, rom_num);
        end else begin
          e = exp_q.pop_front();
          if (rom_num !== AW'(e)) begin
            n_fail++;
            $display("FAIL addr_stage%0d_n%0d: got %0d, required %0d", stg, issued, rom_num, e);
          end
        end
        if (issued < N) obs[issued] = int'(rom_num);
        issued++;
        last_num = int'(rom_num);
      end else if (issued > 0 && issued < N) begin
        gap_cycles++;
        n_checks++;
        if (int'(rom_num) !== last_num) begin
          n_fail++;
          $display("FAIL hold_stage%0d: rom_num=%0d while invalid, required %0d", stg, rom_num, last_num);
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_iter = it;
        n_checks++;
        if (last_out !== 1'b1 || issued != N) begin
          n_fail++;
          $display("FAIL done_stage%0d: last_out=%b issued=%0d, required 1 and %0d", stg, last_out, issued, N);
        end
      end
      if (done_iter > 0 && it == done_iter + 1) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_drop_stage%0d: busy=%b after done, required 0", stg, busy);
        end
        finished = 1;
      end else if (busy !== 1'b1) begin
        n_checks++;
        n_fail++;
        $display("FAIL busy_stage%0d: busy=%b at cycle %0d, required 1", stg, busy, it);
      end
      if (issued == stall_at && stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end
      if (issued == poke_at) begin
        start = 1'b1;
        stage = SW'(stg ^ 1);
      end
    end
    n_checks++;
    if (!finished) begin
      n_fail++;
      $display("FAIL timeout_stage%0d: pass not finished, issued=%0d", stg, issued);
    end
    n_checks++;
    if (first_iter != 1 || done_cnt != 1 || last_iter != done_iter - RL) begin
      n_fail++;
      $display("FAIL timing_stage%0d: first=%0d done_cnt=%0d last=%0d done=%0d, required first=1 done_cnt=1 done=last+%0d",
               stg, first_iter, done_cnt, last_iter, done_iter, RL);
    end
    pass_len = last_iter - first_iter + 1;
    $display("pass stage=%0d issued=%0d len=%0d gaps=%0d", stg, issued, pass_len, gap_cycles);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; stage = '0; stall = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rom_num !== '0 || rom_vld !== 1'b0 || last_out !== 1'b0 || done !== 1'b0 ||
        busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: num=%0d vld=%b last=%b done=%b busy=%b err=%b, required all 0",
               rom_num, rom_vld, last_out, done, busy, err);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || rom_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b vld=%b, required 0 0", busy, rom_vld);
    end
    $display("reset checked");
  endtask

  task automatic test_sequential();
    run_pass(0, 1'b0, -1, 0, -1);
    n_checks++;
    if (pass_len != N || obs[383] != 383) begin
      n_fail++;
      $display("FAIL seq_pass: len=%0d obs[383]=%0d, required %0d and 383", pass_len, obs[383], N);
    end
  endtask

  task automatic test_stride();
    run_pass(7, 1'b0, -1, 0, -1);
    n_checks++;
    if (obs[1] != 128 || obs[2] != 256 || obs[3] != 0 || obs[383] != 256) begin
      n_fail++;
      $display("FAIL stride7: obs1=%0d obs2=%0d obs3=%0d obs383=%0d, required 128 256 0 256",
               obs[1], obs[2], obs[3], obs[383]);
    end
    run_pass(2, 1'b0, -1, 0, -1);
    n_checks++;
    if (obs[95] != 380 || obs[96] != 0) begin
      n_fail++;
      $display("FAIL wrap_stage2: obs95=%0d obs96=%0d, required 380 0", obs[95], obs[96]);
    end
  endtask

  task automatic test_stall();
    run_pass(0, 1'b0, 10, 5, -1);
    n_checks++;
    if (pass_len != N + 5 || gap_cycles != 5) begin
      n_fail++;
      $display("FAIL stall_len: len=%0d gaps=%0d, required %0d and 5", pass_len, gap_cycles, N + 5);
    end
  endtask

  task automatic test_back_to_back();
    run_pass(0, 1'b0, -1, 0, 50);
    run_pass(3, 1'b1, -1, 0, -1);
    n_checks++;
    if (pass_len != N) begin
      n_fail++;
      $display("FAIL b2b_len: len=%0d, required %0d", pass_len, N);
    end
  endtask

  task automatic test_err();
    run_pass(5, 1'b0, -1, 0, -1);
    @(negedge clk);
    start = 1'b1;
    stage = SW'(8);
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse: err=%b busy=%b, required 1 0", err, busy);
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b0 || rom_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err=%b busy=%b vld=%b, required 0 0 0", err, busy, rom_vld);
    end
    $display("err checked stage=8");
  endtask

  task automatic test_reset_mid_pass();
    int issued = 0;
    int seen = 0;
    int e;
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(i % N);
    @(negedge clk);
    start = 1'b1;
    stage = '0;
    @(negedge clk);
    start = 1'b0;
    for (int it = 0; it < 600 && issued < 200; it++) begin
      @(negedge clk);
      if (rom_vld === 1'b1) begin
        e = exp_q.pop_front();
        n_checks++;
        if (rom_num !== AW'(e)) begin
          n_fail++;
          $display("FAIL rst_pass_addr: got %0d, required %0d", rom_num, e);
        end
        issued++;
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (issued != 200 || rom_num !== '0 || rom_vld !== 1'b0 || last_out !== 1'b0 ||
        done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: issued=%0d num=%0d vld=%b last=%b done=%b busy=%b err=%b, required 200 and all 0",
               issued, rom_num, rom_vld, last_out, done, busy, err);
    end
    for (int it = 0; it < 250; it++) begin
      @(negedge clk);
      if (rom_vld === 1'b1 || done === 1'b1 || busy === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL post_reset_quiet: %0d active cycles, required 0", seen);
    end
    exp_q.delete();
    run_pass(1, 1'b0, -1, 0, -1);
    n_checks++;
    if (obs[1] != 2 || obs[2] != 4 || obs[191] != 382 || obs[192] != 0) begin
      n_fail++;
      $display("FAIL after_reset_stage1: %0d %0d %0d %0d, required 2 4 382 0",
               obs[1], obs[2], obs[191], obs[192]);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stride();
    test_stall();
    test_back_to_back();
    test_err();
    test_reset_mid_pass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
